// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame arbiter: FSM encoding, grant codes
// and the helper that turns a phase length into a terminal counter value.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLoad,
        StWaitSent,
        StHold,
        StGap
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_A    = 2'b01;
    localparam logic [1:0] GNT_B    = 2'b10;

    // A phase that must span `cycles` clocks is shortened by one cycle, because its
    // neighbouring single-cycle state supplies the remaining clock. The result is
    // never shorter than one cycle.
    function automatic logic [7:0] phase_last(input int unsigned cycles);
        return (cycles > 32'd1) ? 8'(cycles - 32'd2) : 8'd0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The combinational grant favours the requester that
// was not granted last; the pointer only moves when the caller commits a grant.
module rr_arb2
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_gnt
);

    logic r_prefer_b;

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_req[0] && (!i_req[1] || !r_prefer_b)) begin
            o_gnt = GNT_A;
        end else if (i_req[1]) begin
            o_gnt = GNT_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prefer_b <= 1'b0;
        end else if (i_upd && (|i_req)) begin
            r_prefer_b <= o_gnt[0];
        end
    end

endmodule

// File: rtl/spi_frame_arbiter.sv
// Arbitrates two byte-stream requesters onto one SPI device: owns chip select,
// feeds the byte transmitter one byte at a time and enforces setup/hold/gap timing.
module spi_frame_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] data_a,
    input  logic [7:0] data_b,
    input  logic       valid_a,
    input  logic       valid_b,
    input  logic       last_a,
    input  logic       last_b,
    output logic       ready_a,
    output logic       ready_b,
    output logic [1:0] gnt,
    output logic       cs_n,
    output logic       busy,
    output logic       tx_rd_en,
    output logic [7:0] tx_data,
    input  logic       tx_sent
);

    // LOAD completes the setup window and WAIT_SENT starts the hold window, so the
    // counted phases are one cycle shorter than the parameters.
    localparam logic [7:0] SETUP_LAST = phase_last(CS_SETUP);
    localparam logic [7:0] HOLD_LAST  = phase_last(CS_HOLD);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [1:0]  r_gnt;
    logic        r_cs_n;
    logic        r_tx_rd_en;
    logic [7:0]  r_tx_data;
    logic        r_last;
    logic        w_ready_a;
    logic        w_ready_b;
    logic        w_hs;
    logic [1:0]  w_arb_gnt;
    logic        w_arb_upd;

    assign w_arb_upd = (r_state == StIdle);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req ({req_b, req_a}),
        .i_upd (w_arb_upd),
        .o_gnt (w_arb_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready_a   = 1'b0;
        w_ready_b   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (req_a || req_b) begin
                    w_state_nxt = StSetup;
                    w_cnt_nxt   = 8'd0;
                end
            end
            StSetup: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = StLoad;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            StLoad: begin
                w_ready_a = r_gnt[0] & valid_a;
                w_ready_b = r_gnt[1] & valid_b;
                if (w_ready_a || w_ready_b) begin
                    w_state_nxt = StWaitSent;
                end
            end
            StWaitSent: begin
                if (tx_sent) begin
                    w_state_nxt = r_last ? StHold : StLoad;
                end
            end
            StHold: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = StGap;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            StGap: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign w_hs = w_ready_a | w_ready_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_gnt      <= GNT_NONE;
            r_cs_n     <= 1'b1;
            r_tx_rd_en <= 1'b0;
            r_tx_data  <= 8'd0;
            r_last     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_rd_en <= w_hs;
            if (r_state == StIdle && w_state_nxt == StSetup) begin
                r_gnt  <= w_arb_gnt;
                r_cs_n <= 1'b0;
            end
            if (r_state == StHold && w_state_nxt == StGap) begin
                r_gnt  <= GNT_NONE;
                r_cs_n <= 1'b1;
            end
            if (w_hs) begin
                r_tx_data <= r_gnt[1] ? data_b : data_a;
                r_last    <= r_gnt[1] ? last_b : last_a;
            end
        end
    end

    assign ready_a  = w_ready_a;
    assign ready_b  = w_ready_b;
    assign gnt      = r_gnt;
    assign cs_n     = r_cs_n;
    assign busy     = (r_state != StIdle);
    assign tx_rd_en = r_tx_rd_en;
    assign tx_data  = r_tx_data;

endmodule

// File: doc/spi_frame_arbiter.md
SPI_FRAME_ARBITER -- requirements
Module: spi_frame_arbiter

Interface
REQ-001 The block SHALL have parameter CS_SETUP, default 4: clk cycles from cs_n falling to the first tx_rd_en pulse, range 1..255.
REQ-002 The block SHALL have parameter CS_HOLD, default 4: clk cycles from tx_sent of the last byte to cs_n rising, range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports req_a and req_b, input, 1 bit each: the requester wants a frame.
REQ-006 The block SHALL have ports data_a and data_b, input, 8 bits each: the next byte of the frame.
REQ-007 The block SHALL have ports valid_a and valid_b, input, 1 bit each: the matching data port holds a byte.
REQ-008 The block SHALL have ports last_a and last_b, input, 1 bit each: the offered byte is the final byte of the frame.
REQ-009 The block SHALL have ports ready_a and ready_b, output, 1 bit each: the byte is consumed this cycle.
REQ-010 The block SHALL have port gnt, output, 2 bits, one-hot: bit0 grants A, bit1 grants B.
REQ-011 The block SHALL have port cs_n, output, 1 bit: active-low chip select to the device.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port tx_rd_en, output, 1 bit: single-cycle start pulse to the byte transmitter.
REQ-014 The block SHALL have port tx_data, output, 8 bits: the byte to transmit.
REQ-015 The block SHALL have port tx_sent, input, 1 bit: completion pulse from the byte transmitter.

Function
REQ-016 The block SHALL implement states IDLE, SETUP, LOAD, WAIT_SENT, HOLD and GAP.
REQ-017 In IDLE, if any req is high, the block SHALL grant round-robin: the requester other than the last-granted one wins ties, A wins the first tie after reset, gnt SHALL be registered, and the next state SHALL be SETUP.
REQ-018 In SETUP, cs_n SHALL be 0 and a counter SHALL run for CS_SETUP cycles before the state moves to LOAD.
REQ-019 In LOAD, ready_x SHALL be combinational and equal to gnt_x AND valid_x; on a handshake the block SHALL register tx_data from data_x, pulse tx_rd_en for one cycle, latch last_x, and move to WAIT_SENT.
REQ-020 In LOAD, while valid is low, the block SHALL stall indefinitely with cs_n held at 0.
REQ-021 In WAIT_SENT, on tx_sent the block SHALL move to HOLD if the latched last is set, otherwise to LOAD.
REQ-022 The next tx_rd_en SHALL occur no earlier than one cycle after tx_sent.
REQ-023 In HOLD, after CS_HOLD cycles the block SHALL set cs_n to 1 and move to GAP.
REQ-024 GAP SHALL last exactly one cycle with gnt = 00, then the block SHALL return to IDLE, giving a minimum cs_n high time of 2 cycles.
REQ-025 The block SHALL NOT preempt a frame: req changes after grant SHALL be ignored, and only the granted requester's last ends the frame.
REQ-026 Valid, data and last of the non-granted requester SHALL be ignored, and its ready SHALL be 0.
REQ-027 A tx_sent arriving outside WAIT_SENT SHALL be ignored.
REQ-028 tx_rd_en SHALL never be high for two consecutive cycles.
REQ-029 A one-byte frame (last set on the first byte) SHALL produce exactly one tx_rd_en pulse.
REQ-030 gnt SHALL stay constant from SETUP through HOLD.

Reset
REQ-031 While rst_n is low, the block SHALL force state = IDLE, cs_n = 1, tx_rd_en = 0, tx_data = 0, gnt = 00, busy = 0, counters = 0, and the round-robin pointer to "A next".
REQ-032 Reset mid-frame SHALL abort immediately: cs_n SHALL rise asynchronously, and no further tx_rd_en SHALL be issued until after deassertion.

Structure
REQ-033 The state encoding and the 2-bit grant constants (GNT_NONE, GNT_A, GNT_B) SHALL reside in the shared package spi_pkg.
REQ-034 One sub-module SHALL be used: rr_arb2, a 2-input round-robin arbiter with a registered last-grant pointer; all other logic SHALL be inline.

Verification
REQ-035 The bench SHALL cover this scenario: after reset, req_a alone sends frame 0xA5,0x3C (last on 0x3C) -> gnt=01, cs_n low for CS_SETUP=4 cycles before the first tx_rd_en with tx_data=0xA5, exactly 2 pulses, cs_n high 4 cycles after the second tx_sent.
REQ-036 The bench SHALL cover this scenario: req_a and req_b rise in the same cycle, both persistent, and each sends 1 byte (0x11 for A, 0x22 for B) -> grant order A, B, A, B; cs_n high for at least 2 cycles between frames.
REQ-037 The bench SHALL cover this scenario: granted A drops valid for 10 cycles between bytes -> cs_n stays 0, no tx_rd_en, ready_a=0, and the frame resumes on valid.
REQ-038 The bench SHALL cover this scenario: tx_sent is injected while in LOAD and in IDLE -> no state change and no extra tx_rd_en.
REQ-039 The bench SHALL cover this scenario: rst_n is asserted during WAIT_SENT of byte 2 of 4 -> cs_n=1 in the same cycle; after release, req_b is granted a fresh frame starting at SETUP.
REQ-040 The bench SHALL cover this scenario: a 256-byte frame from B with req_a held high throughout -> gnt stays 10 until GAP, then A is granted.
